// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller between EX/MEM and the data-memory bus.
// Non-memory ops pass to Writeback after one cycle. Loads/stores become req/ack bus
// transactions with Execute stalled until completion, a misalignment/illegal trap or a
// bus timeout.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ex_*                operation from Execute; ex_ready is the accept handshake
//   flush               drop the op presented this cycle (ignored while busy)
//   mem_*               word-aligned bus request, byte enables, lane-replicated store data
//   wb_*                one-cycle result pulse to Writeback with trap flags
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misaligned,
  output logic              wb_bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;

  logic              is_mem;
  logic              illegal;
  logic              misaligned;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_sh;
  logic [DATA_W-1:0] load_data;

  assign ex_ready = (state_q == StIdle) && rst_n;

  // Decode of the op presented by Execute; load+store together counts as a store.
  always_comb begin
    is_mem     = ex_is_load || ex_is_store;
    illegal    = ex_is_store ? (ex_funct3 >= 3'b011)
                             : (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 ||
                                ex_funct3 == 3'b111);
    misaligned = (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00) ||
                 (ex_funct3[1:0] == 2'b01 && ex_addr[0]);
    be        = 4'b1111;
    wdata_rep = ex_wdata;
    unique case (ex_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << ex_addr[1:0];
        wdata_rep = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << ex_addr[1:0];
        wdata_rep = {2{ex_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = ex_wdata;
      end
    endcase
  end

  // Lane select and extension of the returning load data.
  always_comb begin
    rdata_sh = mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{(DATA_W-8){rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  load_data = {{(DATA_W-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, rdata_sh[7:0]};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, rdata_sh[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      is_load_q     <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      reg_write_q   <= 1'b0;
      rd_q          <= 5'd0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_data       <= '0;
      wb_misaligned <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else begin
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_bus_err    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ex_valid && !flush) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= DATA_W'(ex_addr);
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (illegal || misaligned) begin
              wb_valid      <= 1'b1;
              wb_misaligned <= 1'b1;
              wb_reg_write  <= 1'b0;
              wb_rd         <= ex_rd;
              wb_data       <= '0;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= ex_is_store;
              mem_addr    <= {ex_addr[ADDR_W-1:2], 2'b00};
              mem_be      <= be;
              mem_wdata   <= wdata_rep;
              is_load_q   <= !ex_is_store;
              funct3_q    <= ex_funct3;
              lane_q      <= ex_addr[1:0];
              reg_write_q <= ex_reg_write;
              rd_q        <= ex_rd;
              cnt_q       <= '0;
              state_q     <= StAccess;
            end
          end
        end
        StAccess: begin
          // Ack wins over a timeout landing on the same edge.
          if (mem_ack) begin
            mem_req      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_q;
            wb_reg_write <= is_load_q && reg_write_q;
            wb_data      <= is_load_q ? load_data : '0;
            state_q      <= StIdle;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            mem_req      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_bus_err   <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= rd_q;
            wb_data      <= '0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
